// File: rtl/list_sum_ctrl.sv
// Control FSM for the linked-list summing datapath: clears it, walks the list from address 0, latches the sum.
// Latency: N-node list gives done 2N+2 cycles after start is sampled; start is taken only in IDLE, otherwise ignored.
module list_sum_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_NODES  = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  next_zero,
  input  logic [DATA_WIDTH-1:0] sum_out,
  output logic                  ld_sum,
  output logic                  ld_next,
  output logic                  sum_sel,
  output logic                  next_sel,
  output logic                  a_sel,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] result,
  output logic [DATA_WIDTH-1:0] node_cnt
);

  localparam logic [DATA_WIDTH-1:0] MAX_CNT = DATA_WIDTH'(MAX_NODES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_ACC,
    S_LINK,
    S_DONE,
    S_ERR
  } state_t;

  state_t                state_q, state_d;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] result_q;
  logic [DATA_WIDTH-1:0] cnt_q;
  logic                  accept;
  logic                  walk_end;
  logic                  guard_hit;

  always_comb begin
    state_d   = state_q;
    ld_sum    = 1'b0;
    ld_next   = 1'b0;
    sum_sel   = 1'b0;
    next_sel  = 1'b0;
    a_sel     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    walk_end  = 1'b0;
    guard_hit = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = S_INIT;
        end
      end
      S_INIT: begin
        busy     = 1'b1;
        ld_sum   = 1'b1;
        sum_sel  = 1'b1;
        ld_next  = 1'b1;
        next_sel = 1'b1;
        state_d  = S_ACC;
      end
      S_ACC: begin
        busy    = 1'b1;
        ld_sum  = 1'b1;
        state_d = S_LINK;
      end
      S_LINK: begin
        busy    = 1'b1;
        a_sel   = 1'b1;
        ld_next = 1'b1;
        // A zero link wins over the guard: a list of exactly MAX_NODES is legal.
        if (next_zero) begin
          walk_end = 1'b1;
          state_d  = S_DONE;
        end else if (cnt_q == MAX_CNT) begin
          walk_end  = 1'b1;
          guard_hit = 1'b1;
          state_d   = S_ERR;
        end else begin
          state_d = S_ACC;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      S_ERR: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      err_q    <= 1'b0;
      result_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        err_q <= 1'b0;
        cnt_q <= '0;
      end else if (state_q == S_ACC && cnt_q != MAX_CNT) begin
        cnt_q <= cnt_q + DATA_WIDTH'(1);
      end
      if (walk_end) begin
        result_q <= sum_out;
      end
      if (guard_hit) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err      = err_q;
  assign result   = result_q;
  assign node_cnt = cnt_q;

endmodule

// File: tb/tb_list_sum_ctrl.sv
// Bench for list_sum_ctrl: a datapath/memory model closes the loop; walks are checked against a list-walk model.
module tb_list_sum_ctrl;

  localparam int MAXN = 4;

  logic       clk;
  logic       rst;
  logic       start;
  logic       next_zero;
  logic [7:0] sum_out;
  logic       ld_sum, ld_next, sum_sel, next_sel, a_sel;
  logic       busy, done, err;
  logic [7:0] result, node_cnt;

  list_sum_ctrl #(.DATA_WIDTH(8), .MAX_NODES(MAXN)) dut (
    .clk(clk), .rst(rst), .start(start), .next_zero(next_zero), .sum_out(sum_out),
    .ld_sum(ld_sum), .ld_next(ld_next), .sum_sel(sum_sel), .next_sel(next_sel),
    .a_sel(a_sel), .busy(busy), .done(done), .err(err),
    .result(result), .node_cnt(node_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath and memory the controller steers.
  logic [7:0] mem [256];
  logic [7:0] sum_r, next_r, mem_addr, mem_dat, next_mux;

  always_comb begin
    mem_addr = a_sel ? next_r : next_r + 8'd1;
    mem_dat  = mem[mem_addr];
    next_mux = next_sel ? 8'd0 : mem_dat;
  end
  assign next_zero = (next_mux == 8'd0);
  assign sum_out   = sum_r;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_r  <= '0;
      next_r <= '0;
    end else begin
      if (ld_sum)  sum_r  <= sum_sel ? 8'd0 : sum_r + mem_dat;
      if (ld_next) next_r <= next_mux;
    end
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input string what, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s/%s: got %0d expected %0d", tag, what, act, exp);
    end
  endtask

  function automatic int all_outs();
    return int'({ld_sum, ld_next, sum_sel, next_sel, a_sel, busy, done, err, result, node_cnt});
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'd0;
  endtask

  // Called #1 after a rising edge with the controller idle.
  task automatic run_walk(input string tag, input int er, input int ec, input int ee,
                          input int ey, input int poke);
    int cyc;
    int nd;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    check(tag, "init_busy", int'(busy), 1);
    check(tag, "err_cleared", int'(err), 0);
    check(tag, "cnt_cleared", int'(node_cnt), 0);
    while (!done && cyc < 300) begin
      if (cyc == poke) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    check(tag, "done_seen", int'(done), 1);
    check(tag, "done_cycle", cyc, ey);
    check(tag, "result", int'(result), er);
    check(tag, "node_cnt", int'(node_cnt), ec);
    check(tag, "err", int'(err), ee);
    check(tag, "busy_at_done", int'(busy), 0);
    nd = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done || busy) nd++;
    end
    check(tag, "quiet_after_done", nd, 0);
    check(tag, "err_held", int'(err), ee);
    check(tag, "result_held", int'(result), er);
  endtask

  typedef struct {
    string           name;
    logic [0:9][7:0] w;
    int              res;
    int              cnt;
    int              er;
    int              cyc;
  } vec_t;

  function automatic vec_t mk(input string n, input logic [0:9][7:0] w,
                              input int r, input int c, input int e, input int y);
    vec_t v;
    v.name = n; v.w = w; v.res = r; v.cnt = c; v.er = e; v.cyc = y;
    return v;
  endfunction

  task automatic load_vec(input vec_t v);
    clear_mem();
    for (int i = 0; i < 10; i++) mem[i] = v.w[i];
  endtask

  vec_t tbl [7];

  initial begin
    int p, s, n, e, nd;

    tbl[0] = mk("three_node", {8'd2, 8'd5, 8'd4, 8'd7, 8'd0, 8'd9, 8'd0, 8'd0, 8'd0, 8'd0}, 21, 3, 0, 8);
    tbl[1] = mk("one_node",   {8'd0, 8'd200, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 200, 1, 0, 4);
    tbl[2] = mk("wrap",       {8'd2, 8'd200, 8'd0, 8'd100, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 44, 2, 0, 6);
    tbl[3] = mk("wrap_zero",  {8'd2, 8'd255, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 0, 2, 0, 6);
    tbl[4] = mk("exact_max",  {8'd2, 8'd1, 8'd4, 8'd2, 8'd6, 8'd3, 8'd0, 8'd4, 8'd0, 8'd0}, 10, 4, 0, 10);
    tbl[5] = mk("runaway",    {8'd2, 8'd1, 8'd4, 8'd2, 8'd6, 8'd3, 8'd8, 8'd4, 8'd0, 8'd5}, 10, 4, 1, 10);
    tbl[6] = mk("loop",       {8'd2, 8'd1, 8'd2, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 10, 4, 1, 10);

    rst = 1'b0;
    start = 1'b0;
    clear_mem();
    repeat (2) @(posedge clk);
    #1;
    check("reset", "outputs_zero", all_outs(), 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("reset", "idle_after_release", all_outs(), 0);

    for (int i = 0; i < 7; i++) begin
      load_vec(tbl[i]);
      run_walk(tbl[i].name, tbl[i].res, tbl[i].cnt, tbl[i].er, tbl[i].cyc, 0);
    end

    // err left set by the loop walk; the next accepted start clears it.
    check("err_sticky", "err", int'(err), 1);
    load_vec(tbl[0]);
    run_walk("after_err", 21, 3, 0, 8, 0);

    // start pulsed mid-walk must be ignored.
    load_vec(tbl[1]);
    run_walk("prime", 200, 1, 0, 4, 0);
    load_vec(tbl[0]);
    run_walk("start_while_busy", 21, 3, 0, 8, 4);

    // Asynchronous reset during ACC.
    load_vec(tbl[0]);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("mid_reset", "in_acc", int'(ld_sum & ~sum_sel & busy), 1);
    rst = 1'b0;
    #1;
    check("mid_reset", "outputs_zero", all_outs(), 0);
    nd = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    check("mid_reset", "no_done", nd, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    run_walk("restart", 21, 3, 0, 8, 0);

    // Random lists in a 16-word window against a plain list-walk model.
    for (int t = 0; t < 25; t++) begin
      clear_mem();
      for (int k = 0; k < 8; k++) begin
        mem[2*k]   = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'(2 * $urandom_range(0, 7));
        mem[2*k+1] = 8'($urandom_range(0, 255));
      end
      p = 0; s = 0; n = 0; e = 0;
      forever begin
        s = s + int'(mem[p+1]);
        n++;
        p = int'(mem[p]);
        if (p == 0) break;
        if (n == MAXN) begin
          e = 1;
          break;
        end
      end
      run_walk($sformatf("rand%0d", t), s % 256, n, e, 2 * n + 2, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
